i2c_cmd_sequencer: RTL

Command queue and transaction sequencer placed directly upstream of the I2C master driver. Accepts I2C transaction commands (R/W, 10-bit address, write byte) over a valid/ready interface and buffers them in a small FIFO. Issues them one at a time to the driver through its start/busy interface. Returns one response per command (read byte, status) over a valid/ready interface.

---
 rtl/i2c_cmd_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: buffers I2C commands and runs them one at a time on the I2C master driver.
// Latency: command accepted at N -> popped at N+1 -> drv_start at N+2; response the cycle after busy drops.
// Backpressure: cmd_ready = !full (no push-through on a full FIFO); RESPOND holds until rsp_ready.
// Optional per-transaction watchdog is built when I2C_SEQ_TIMEOUT_EN is defined.

// Generic synchronous FIFO: registered pointers, no bypass; caller gates push/pop with full/empty.
module i2c_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign pop_dat = mem[rd_ptr];

   // pointers wrap naturally at DEPTH (power of two); simultaneous push/pop keeps count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // storage array, written at the tail
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end
endmodule

module i2c_cmd_sequencer #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_rw,
   input  logic [9:0]             cmd_addr,
   input  logic [7:0]             cmd_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_rw,
   output logic [7:0]             rsp_rdata,
   output logic                   rsp_timeout,
   output logic                   drv_start,
   output logic                   drv_rw,
   output logic [9:0]             drv_addr,
   output logic [7:0]             drv_wdata,
   input  logic                   drv_busy,
   input  logic [7:0]             drv_rdata,
   output logic [$clog2(DEPTH):0] cmd_count,
   output logic                   idle
);
   typedef struct packed {
      logic       rw;
      logic [9:0] addr;
      logic [7:0] wdata;
   } cmd_t;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESPOND} state_t;

   state_t state;
   state_t state_nxt;
   cmd_t   push_cmd;
   cmd_t   head;
   logic   fifo_full;
   logic   fifo_empty;
   logic   push;
   logic   pop;
   logic   done_ok;
   logic   tmo_hit;
   logic   tmo_fire;

   assign push_cmd  = {cmd_rw, cmd_addr, cmd_wdata};
   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && !fifo_full;

   i2c_seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(cmd_t))
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (push_cmd),
      .pop      (pop),
      .pop_dat  (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (cmd_count)
   );

`ifdef I2C_SEQ_TIMEOUT_EN
   // Expiry is taken when the count is about to reach TIMEOUT_CYCLES-1, so RESPOND
   // begins TIMEOUT_CYCLES cycles after the start pulse.
   localparam logic [15:0] TMO_ARM = 16'(TIMEOUT_CYCLES - 2);
   logic [15:0] wdog;

   assign tmo_hit = (wdog == TMO_ARM);

   // watchdog: cleared on the way into WAIT_ACCEPT, counts while waiting on the driver
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wdog <= '0;
      else if (state == ISSUE)
         wdog <= '0;
      else if (state == WAIT_ACCEPT || state == WAIT_DONE)
         wdog <= wdog + 1'b1;
   end

   // timeout flag travels with each response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rsp_timeout <= 1'b0;
      else if (done_ok || tmo_fire)
         rsp_timeout <= tmo_fire;
   end
`else
   assign tmo_hit     = 1'b0;
   assign rsp_timeout = 1'b0;
   wire   unused_tmo  = tmo_fire | (TIMEOUT_CYCLES > 1);
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state, pop and completion strobes
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      done_ok   = 1'b0;
      tmo_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && !drv_busy) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT_ACCEPT;
         WAIT_ACCEPT: begin
            if (tmo_hit) begin
               tmo_fire  = 1'b1;
               state_nxt = RESPOND;
            end else if (drv_busy) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!drv_busy) begin
               done_ok   = 1'b1;
               state_nxt = RESPOND;
            end else if (tmo_hit) begin
               tmo_fire  = 1'b1;
               state_nxt = RESPOND;
            end
         end
         RESPOND: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // driver command registers: loaded on pop, stable until the next pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drv_rw    <= 1'b0;
         drv_addr  <= '0;
         drv_wdata <= '0;
      end else if (pop) begin
         drv_rw    <= head.rw;
         drv_addr  <= head.addr;
         drv_wdata <= head.wdata;
      end
   end

   // response capture: read data only for a completed read, zero otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rw    <= 1'b0;
         rsp_rdata <= '0;
      end else if (done_ok || tmo_fire) begin
         rsp_rw    <= drv_rw;
         rsp_rdata <= (done_ok && drv_rw) ? drv_rdata : 8'h00;
      end
   end

   assign drv_start = (state == ISSUE);
   assign rsp_valid = (state == RESPOND);
   assign idle      = (state == IDLE) && fifo_empty && !drv_busy;
endmodule
